// File: rtl/cheesehat_sprite_pkg.sv
// Shared definitions for the cheesehat sprite fetcher.
// Contents:
//   - Geometry and format constants for the 32x32, 8 bpp sprite RAM.
//   - Row/column field widths used to form the RAM address.
//   - The fetcher state enum.
package cheesehat_sprite_pkg;

  localparam int unsigned SPRITE_W  = 32;
  localparam int unsigned SPRITE_H  = 32;
  localparam int unsigned PIX_W     = 8;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned COORD_W   = 10;
  localparam int unsigned SCREEN_W  = 640;
  localparam logic [PIX_W-1:0] KEY_COLOR = 8'h00;

  // The RAM address is the concatenation {row, col}.
  localparam int unsigned COL_W = $clog2(SPRITE_W);
  localparam int unsigned ROW_W = ADDR_W - COL_W;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/cheesehat_sprite_fetcher.sv
// cheesehat_sprite_fetcher
// Fetches one row of the cheesehat sprite from its 1024x8 on-chip RAM for the
// scanline being built. It streams opaque, on-screen pixels (with screen x)
// toward the VGA line-buffer writer.
//
// Ports:
//   clk, reset       - clock; synchronous active-high reset
//   start            - one-cycle line request (accepted only when idle)
//   line_y           - scanline being built
//   sprite_x         - sprite left edge
//   sprite_y         - sprite top edge
//   busy             - high from accepted start until done
//   done             - one-cycle pulse when the line is finished
//   mem_address      - sprite RAM read port address
//   mem_chipselect   - sprite RAM read port select
//   mem_clken        - sprite RAM read port clock enable
//   mem_readdata     - sprite RAM read port data, one cycle after the address edge
//   pix_valid        - valid/ready pixel stream: valid
//   pix_ready        - valid/ready pixel stream: ready
//   pix_data         - pixel colour
//   pix_x            - screen x of the pixel
//   mirror           - horizontal flip, sampled on start
//                      (present only with CHEESEHAT_SPRITE_MIRROR_EN)
//
// Optional feature macro: CHEESEHAT_SPRITE_MIRROR_EN.
module cheesehat_sprite_fetcher
  import cheesehat_sprite_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] line_y,
  input  logic [COORD_W-1:0] sprite_x,
  input  logic [COORD_W-1:0] sprite_y,
`ifdef CHEESEHAT_SPRITE_MIRROR_EN
  input  logic               mirror,
`endif
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  mem_address,
  output logic               mem_chipselect,
  output logic               mem_clken,
  input  logic [PIX_W-1:0]   mem_readdata,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [PIX_W-1:0]   pix_data,
  output logic [COORD_W-1:0] pix_x
);

  localparam logic [COL_W-1:0]   LastCol     = COL_W'(SPRITE_W - 1);
  localparam logic [COORD_W:0]   RowLimit    = (COORD_W + 1)'(SPRITE_H);
  localparam logic [COORD_W:0]   ScreenLimit = (COORD_W + 1)'(SCREEN_W);

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   row_q;
  logic [COL_W-1:0]   col_q;
  logic [COORD_W-1:0] sx_q;
  logic               rd_valid_q;   // mem_readdata holds a column issued earlier
  logic [COL_W-1:0]   rd_col_q;     // column that mem_readdata belongs to
  logic               pix_valid_q;
  logic [PIX_W-1:0]   pix_data_q;
  logic [COORD_W-1:0] pix_x_q;

  logic               stall;
  logic               issue_fire;
  logic               row_hit;
  logic               keep;
  logic [COORD_W:0]   row_diff;
  logic [COORD_W:0]   pix_x_wide;
  logic [COL_W-1:0]   mem_col;

  // Signed difference; a set top bit means the line is above the sprite.
  assign row_diff   = {1'b0, line_y} - {1'b0, sprite_y};
  assign row_hit    = !row_diff[COORD_W] && (row_diff < RowLimit);

  // A held, unaccepted pixel freezes the whole read pipeline.
  assign stall      = pix_valid_q && !pix_ready;
  assign issue_fire = (state_q == StIssue) && !stall;

  // One extra bit so sprites hanging off the right edge never wrap back on.
  assign pix_x_wide = {1'b0, sx_q} + (COORD_W + 1)'(rd_col_q);
  assign keep       = (pix_x_wide < ScreenLimit) && (mem_readdata != KEY_COLOR);

`ifdef CHEESEHAT_SPRITE_MIRROR_EN
  logic mirror_q;
  // SPRITE_W is a power of two, so SPRITE_W-1-col is a bitwise inversion.
  assign mem_col = col_q ^ {COL_W{mirror_q}};

  always_ff @(posedge clk) begin
    if (reset) begin
      mirror_q <= 1'b0;
    end else if (state_q == StIdle && start) begin
      mirror_q <= mirror;
    end
  end
`else
  assign mem_col = col_q;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = row_hit ? StIssue : StDone;
      StIssue: if (issue_fire && col_q == LastCol) state_d = StDrain;
      // Finish only once the last read has left the output register.
      StDrain: if (!rd_valid_q && !stall) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      row_q       <= '0;
      col_q       <= '0;
      sx_q        <= '0;
      rd_valid_q  <= 1'b0;
      rd_col_q    <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      pix_x_q     <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == StIdle && start) begin
        row_q <= row_diff[ROW_W-1:0];
        col_q <= '0;
        sx_q  <= sprite_x;
      end else if (issue_fire) begin
        col_q <= col_q + 1'b1;
      end

      if (!stall) begin
        rd_valid_q <= issue_fire;
        rd_col_q   <= col_q;
        if (rd_valid_q && keep) begin
          pix_valid_q <= 1'b1;
          pix_data_q  <= mem_readdata;
          pix_x_q     <= pix_x_wide[COORD_W-1:0];
        end else begin
          pix_valid_q <= 1'b0;
        end
      end
    end
  end

  assign busy           = (state_q != StIdle);
  assign done           = (state_q == StDone);
  assign mem_chipselect = (state_q == StIssue);
  assign mem_address    = mem_chipselect ? {row_q, mem_col} : '0;
  assign mem_clken      = !stall;
  assign pix_valid      = pix_valid_q;
  assign pix_data       = pix_data_q;
  assign pix_x          = pix_x_q;

endmodule

// File: tb/tb_cheesehat_sprite_fetcher.sv
// Self-checking bench for cheesehat_sprite_fetcher: table of directed line
// requests, a mid-line reset sequence and randomized requests, all compared
// against a per-line reference model of the expected pixel and address lists.
module tb_cheesehat_sprite_fetcher;
  import cheesehat_sprite_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [COORD_W-1:0] line_y, sprite_x, sprite_y;
  logic               busy, done;
  logic [ADDR_W-1:0]  mem_address;
  logic               mem_chipselect, mem_clken;
  logic [PIX_W-1:0]   mem_readdata = '0;
  logic               pix_valid, pix_ready;
  logic [PIX_W-1:0]   pix_data;
  logic [COORD_W-1:0] pix_x;

  always #5 clk = ~clk;

  cheesehat_sprite_fetcher dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .line_y         (line_y),
    .sprite_x       (sprite_x),
    .sprite_y       (sprite_y),
`ifdef CHEESEHAT_SPRITE_MIRROR_EN
    .mirror         (1'b0),
`endif
    .busy           (busy),
    .done           (done),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .pix_data       (pix_data),
    .pix_x          (pix_x)
  );

  // Sprite RAM: registered read, pipeline held while clken is low.
  logic [PIX_W-1:0] mem [SPRITE_W*SPRITE_H];
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) mem_readdata <= mem[mem_address];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Results of one line run and the model's expectation for it.
  logic [PIX_W+COORD_W-1:0] got_pix[$], exp_pix[$];
  int got_addr[$], exp_addr[$];
  int done_cyc, cs_seen, clken_err, busy_err, post_done;

  // Expected output of a line, straight from the fetch rules.
  task automatic model(input int ly, input int sx, input int sy);
    int row;
    exp_pix.delete();
    exp_addr.delete();
    row = ly - sy;
    if (row >= 0 && row < int'(SPRITE_H)) begin
      for (int c = 0; c < int'(SPRITE_W); c++) begin
        int x;
        logic [PIX_W-1:0] d;
        logic [COORD_W-1:0] xs;
        exp_addr.push_back(row * int'(SPRITE_W) + c);
        x  = sx + c;
        d  = mem[row * int'(SPRITE_W) + c];
        xs = COORD_W'(x);
        if (x < int'(SCREEN_W) && d != KEY_COLOR) exp_pix.push_back({d, xs});
      end
    end
  endtask

  function automatic int first_pix_diff();
    int n = (got_pix.size() > exp_pix.size()) ? got_pix.size() : exp_pix.size();
    for (int i = 0; i < n; i++) begin
      if (i >= got_pix.size() || i >= exp_pix.size()) return i;
      if (got_pix[i] != exp_pix[i]) return i;
    end
    return -1;
  endfunction

  function automatic int first_addr_diff();
    int n = (got_addr.size() > exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      if (i >= got_addr.size() || i >= exp_addr.size()) return i;
      if (got_addr[i] != exp_addr[i]) return i;
    end
    return -1;
  endfunction

  // mode: 0 = always ready, 1 = ready toggles 1/0, 2 = random ready.
  // Cycle 0 is the start cycle; outputs are sampled on the falling edge.
  task automatic run_line(input int ly, input int sx, input int sy, input int mode);
    got_pix.delete();
    got_addr.delete();
    done_cyc  = -1;
    cs_seen   = 0;
    clken_err = 0;
    busy_err  = 0;
    post_done = -1;
    @(posedge clk); #1;
    line_y    = COORD_W'(ly);
    sprite_x  = COORD_W'(sx);
    sprite_y  = COORD_W'(sy);
    start     = 1'b1;
    pix_ready = 1'b1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      case (mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = 1'(cyc % 2);
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (mem_chipselect) begin
        cs_seen = 1;
        if (mem_clken) got_addr.push_back(int'(mem_address));
      end
      if (mem_clken != !(pix_valid && !pix_ready)) clken_err++;
      if (!busy) busy_err++;
      if (pix_valid && pix_ready) got_pix.push_back({pix_data, pix_x});
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    if (done_cyc >= 0) begin
      @(posedge clk); #1;
      pix_ready = 1'b1;
      @(negedge clk);
      post_done = int'({done, busy});
    end
  endtask

  task automatic evaluate(input string tag, input int exp_count, input int exp_done,
                          input int exp_cs);
    check({tag, "_done_seen"}, int'(done_cyc >= 0), 1);
    if (exp_done >= 0) check({tag, "_done_cycle"}, done_cyc, exp_done);
    if (exp_count >= 0) check({tag, "_pix_count"}, got_pix.size(), exp_count);
    check({tag, "_pix_seq_first_diff"}, first_pix_diff(), -1);
    check({tag, "_addr_seq_first_diff"}, first_addr_diff(), -1);
    check({tag, "_chipselect_seen"}, cs_seen, exp_cs);
    check({tag, "_clken_errors"}, clken_err, 0);
    check({tag, "_busy_low_cycles"}, busy_err, 0);
    check({tag, "_after_done_done_busy"}, post_done, 0);
  endtask

  // pat 0: row = 1..SPRITE_W; pat 1: same but key colour at cols 3 and 7.
  task automatic fill_row(input int r, input int pat);
    for (int c = 0; c < int'(SPRITE_W); c++) begin
      mem[r * int'(SPRITE_W) + c] = PIX_W'(c + 1);
    end
    if (pat == 1) begin
      mem[r * int'(SPRITE_W) + 3] = KEY_COLOR;
      mem[r * int'(SPRITE_W) + 7] = KEY_COLOR;
    end
  endtask

  typedef struct {
    int ly, sx, sy, mode;
    int row, pat;
    int exp_count, exp_done, exp_cs;
  } vec_t;

  vec_t vecs[8];

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    pix_ready = 1'b1;
    line_y    = '0;
    sprite_x  = '0;
    sprite_y  = '0;
    for (int i = 0; i < int'(SPRITE_W * SPRITE_H); i++) begin
      mem[i] = ($urandom_range(0, 4) == 0) ? KEY_COLOR : PIX_W'($urandom);
    end

    //            ly   sx   sy  mode row pat count done cs
    vecs[0] = '{55, 100, 50, 0,  5,  0,  32,   35,  1};
    vecs[1] = '{49, 100, 50, 0, -1,  0,   0,    1,  0};
    vecs[2] = '{82, 100, 50, 0, -1,  0,   0,    1,  0};
    vecs[3] = '{55, 100, 50, 1,  5,  0,  32,   -1,  1};
    vecs[4] = '{55, 100, 50, 0,  5,  1,  30,   35,  1};
    vecs[5] = '{55, 620, 50, 0,  5,  0,  20,   35,  1};
    vecs[6] = '{81,   0, 50, 0, 31,  0,  32,   35,  1};
    vecs[7] = '{50,   0, 50, 0,  0,  0,  32,   35,  1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl_busy_done_valid_cs_clken",
          int'({busy, done, pix_valid, mem_chipselect, mem_clken}), 1);
    check("reset_addr_data_x", int'({mem_address, pix_data, pix_x}), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].row >= 0) fill_row(vecs[i].row, vecs[i].pat);
      model(vecs[i].ly, vecs[i].sx, vecs[i].sy);
      run_line(vecs[i].ly, vecs[i].sx, vecs[i].sy, vecs[i].mode);
      evaluate($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_done, vecs[i].exp_cs);
    end

    // Start ignored while busy: a second start mid-line must not restart it.
    begin
      int n;
      fill_row(5, 0);
      @(posedge clk); #1;
      line_y = 10'd55; sprite_x = 10'd100; sprite_y = 10'd50;
      start = 1'b1; pix_ready = 1'b1;
      n = 0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
        @(posedge clk); #1;
        start = (cyc == 5) ? 1'b1 : 1'b0;
        line_y = (cyc == 5) ? 10'd49 : 10'd55;
        @(negedge clk);
        if (pix_valid && pix_ready) n++;
        if (done) break;
      end
      start = 1'b0;
      check("busy_start_ignored_pix_count", n, 32);
    end

    // Mid-line reset after 10 pixels, then a clean line.
    begin
      int n;
      fill_row(5, 0);
      @(posedge clk); #1;
      line_y = 10'd55; sprite_x = 10'd100; sprite_y = 10'd50;
      start = 1'b1; pix_ready = 1'b1;
      n = 0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        if (pix_valid && pix_ready) n++;
        if (n == 10) break;
      end
      check("midreset_reached_10_pixels", n, 10);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("midreset_ctrl_busy_done_valid_cs_clken",
            int'({busy, done, pix_valid, mem_chipselect, mem_clken}), 1);
      check("midreset_addr_data_x", int'({mem_address, pix_data, pix_x}), 0);
      model(55, 100, 50);
      run_line(55, 100, 50, 0);
      evaluate("after_reset", 32, 35, 1);
    end

    // Randomized requests against the model.
    for (int i = 0; i < 24; i++) begin
      int sy, ly, sx, mode, row, hit;
      sy   = $urandom_range(0, 100);
      ly   = sy + $urandom_range(0, 50) - 8;
      if (ly < 0) ly = 0;
      sx   = $urandom_range(0, 700);
      mode = $urandom_range(0, 2);
      row  = ly - sy;
      hit  = (row >= 0 && row < int'(SPRITE_H)) ? 1 : 0;
      model(ly, sx, sy);
      run_line(ly, sx, sy, mode);
      evaluate($sformatf("rand%0d", i), -1, (mode == 0) ? (hit ? 35 : 1) : -1, hit);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cheesehat_sprite_fetcher.md
Name: cheesehat_sprite_fetcher

Overview:
Reader/initiator for the cheesehat sprite on-chip memory, a 1024x8 single-port RAM holding a 32x32 sprite at 8 bits per pixel.
- On each scanline request it checks whether the line crosses the sprite.
- If it does, it reads that sprite row over the memory's address/chipselect/clken/readdata slave port.
- Opaque, on-screen pixels go out as a valid/ready stream with screen x, toward the VGA line-buffer writer.

Parameters:
- SPRITE_W, 32, sprite width in pixels (power of 2).
- SPRITE_H, 32, sprite height in rows.
- PIX_W, 8, pixel width; equals memory data width.
- ADDR_W, 10, memory address width; log2(SPRITE_W*SPRITE_H).
- COORD_W, 10, screen coordinate width.
- SCREEN_W, 640, visible width; pixels with x >= SCREEN_W are dropped.
- KEY_COLOR, 8'h00, transparent colour; such pixels are dropped.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to fetch the current line
- line_y  in  COORD_W  scanline being built; sampled on accepted start
- sprite_x  in  COORD_W  sprite left edge; sampled on accepted start
- sprite_y  in  COORD_W  sprite top edge; sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the line is finished
- mem_address  out  ADDR_W  memory address
- mem_chipselect  out  1  high while issuing reads
- mem_clken  out  1  memory clock enable; low stalls the memory pipeline
- mem_readdata  in  PIX_W  memory data, 1 cycle after the address edge
- pix_valid  out  1  pixel available
- pix_ready  in  1  sink accepts pixel
- pix_data  out  PIX_W  pixel colour
- pix_x  out  COORD_W  screen x of pixel

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset (also when asserted mid-operation): state goes to IDLE and the current line is abandoned. Outputs busy, done, pix_valid, mem_chipselect = 0; mem_address, pix_data, pix_x = 0; mem_clken = 1.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start is accepted only here; start while busy is ignored.
  - On start, compute row = line_y - sprite_y in COORD_W+1 signed arithmetic.
  - If 0 <= row < SPRITE_H: go to ISSUE with col = 0.
  - Otherwise go to DONE with no memory access.
- ISSUE:
  - mem_chipselect = 1; mem_address = row*SPRITE_W + col (concatenation {row[4:0], col[4:0]}).
  - col increments on each cycle that mem_clken = 1.
  - After col = SPRITE_W-1 is issued, go to DRAIN.
- DRAIN: waits until the final readdata has been emitted or dropped, then goes to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE. busy = (state != IDLE).
- Read pipeline: mem_readdata for column c is valid the cycle after c is issued with clken high. A tracked flag qualifies it.
- Pixel handling: x = sprite_x + c, computed in COORD_W+1 bits (no wrap).
  - If x >= SCREEN_W or data == KEY_COLOR, the pixel is dropped silently with no stall.
  - Otherwise the pixel is loaded into the output register, and pix_valid rises.
- Handshake:
  - pix_data and pix_x are held stable while pix_valid && !pix_ready.
  - A transfer occurs when pix_valid && pix_ready.
  - mem_clken = !(pix_valid && !pix_ready). Address, readdata and col freeze during a stall; no pixel is lost or duplicated.
- Latency: start at cycle 0 → address for col 0 at cycle 1 → first pix_valid at cycle 3. With no stalls, done occurs at cycle 35.
- Line miss: done occurs at cycle 1, mem_chipselect stays 0.
- This block never writes memory (write/debugaccess are tied 0 at integration).

Optional Feature:
- Macro: CHEESEHAT_SPRITE_MIRROR_EN.
- Defined: adds input port mirror (1 bit, sampled on start). When mirror = 1, the address column is SPRITE_W-1-col while pix_x still uses col, giving a horizontal flip.
- Undefined: the port is absent and the address always uses col.

Decomposition:
- Package cheesehat_sprite_pkg holds:
  - the state enum (IDLE/ISSUE/DRAIN/DONE);
  - localparams SPRITE_W, SPRITE_H, PIX_W, ADDR_W, COORD_W, SCREEN_W, KEY_COLOR;
  - the row/col field widths.
- Single module, no sub-module; the output register is too small to warrant one.

Test Plan:
1. Sprite memory row 5 = 1..32, sprite_x=100, sprite_y=50, line_y=55, pix_ready=1 → addresses 160..191; 32 pixels with data 1..32 and pix_x 100..131; done at cycle 35.
2. line_y=49 (and separately 82), start → no mem_chipselect, zero pixels, done at cycle 1.
3. Scenario 1 with pix_ready toggling 0/1 each cycle → identical 32-pixel sequence, mem_clken low exactly on stall cycles, no drop or duplication.
4. Row 5 has 8'h00 at cols 3 and 7 → 30 pixels; pix_x skips 103 and 107.
5. sprite_x=620 → 20 pixels with pix_x 620..639, then done.
6. reset asserted after 10 pixels → next cycle all outputs at reset values; a new start then completes normally.
